// File: rtl/serial_rx.sv
// 16x-oversampled asynchronous serial receiver with a valid/ready output register.
// Optional even-parity bit when SERIAL_RX_PARITY_EN is defined.
module serial_rx #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam int unsigned CNT_W = 4;

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               r_state, w_state_nx;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
  logic [IDX_W-1:0]     r_idx, w_idx_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                 r_rx_meta, r_rx_s;
  logic                 w_done, w_ferr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr, r_ovr, r_busy;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic w_perr;
  logic r_perr;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_done     = 1'b0;
    w_ferr     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    w_perr     = 1'b0;
`endif
    if (sample_tick) begin
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            w_state_nx = START;
            w_cnt_nx   = '0;
          end
        end
        START: begin
          // Mid start bit: a line already back high was only a glitch.
          if (r_cnt == 4'd7) begin
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
            w_state_nx = r_rx_s ? IDLE : DATA;
          end else begin
            w_cnt_nx = r_cnt + 4'd1;
          end
        end
        DATA: begin
          w_cnt_nx = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_shift_nx = {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_idx == IDX_W'(DATA_BITS - 1)) begin
              w_idx_nx = '0;
`ifdef SERIAL_RX_PARITY_EN
              w_state_nx = PARITY;
`else
              w_state_nx = STOP;
`endif
            end else begin
              w_idx_nx = r_idx + IDX_W'(1);
            end
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          w_cnt_nx = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_perr     = (r_rx_s != (^r_shift));
            w_state_nx = STOP;
          end
        end
`endif
        STOP: begin
          w_cnt_nx = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_done     = r_rx_s;
            w_ferr     = !r_rx_s;
            w_cnt_nx   = '0;
            w_state_nx = IDLE;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  // Output holding register: a new byte loads only if the slot is free or draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      r_busy <= (w_state_nx != IDLE);
      if (w_done) begin
        if (!r_valid || ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_perr <= 1'b0;
    else      r_perr <= w_perr;
  end
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign data        = r_data;
  assign valid       = r_valid;
  assign framing_err = r_ferr;
  assign overrun     = r_ovr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: accepted bytes are matched against bytes queued at send time.
module tb_serial_rx;

  localparam int unsigned DB  = 8;
  localparam int unsigned BIT = 64;  // clks per bit: 16 ticks, one tick every 4 clks

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_tick = 1'b0;
  logic          rx = 1'b1;
  logic          ready = 1'b1;
  logic [DB-1:0] data;
  logic          valid, framing_err, overrun, parity_err, busy;

  int checks = 0;
  int failures = 0;
  int tdiv = 0;
  int ferr_n = 0, ovr_n = 0, perr_n = 0, vcyc_n = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] got_q[$];

  serial_rx #(.DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx),
    .data(data), .valid(valid), .ready(ready),
    .framing_err(framing_err), .overrun(overrun), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tdiv <= (tdiv == 3) ? 0 : tdiv + 1;
    sample_tick <= (tdiv == 3);
  end

  // Monitor: count pulse cycles and capture handshaken bytes.
  always @(negedge clk) begin
    if (rst) begin
      if (framing_err) ferr_n++;
      if (overrun) ovr_n++;
      if (parity_err) perr_n++;
      if (valid) vcyc_n++;
      if (valid && ready) got_q.push_back(data);
    end
  end

  task automatic drive_bit(input logic b, input int len);
    rx = b;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop_v, input int stop_len,
                            input logic par_force, input logic par_v);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < DB; i++) drive_bit(b[i], BIT);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit(par_force ? par_v : ^b, BIT);
`else
    if (par_force && par_v) rx = 1'b1;
`endif
    drive_bit(stop_v, stop_len);
    drive_bit(1'b1, 3 * BIT);
  endtask

  task automatic check_byte(input string name);
    logic [DB-1:0] e, g;
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got_q=%0d exp_q=%0d entries, required one each", name, got_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== e) begin
        failures++;
        $display("FAIL %s: data=%h required %h", name, g, e);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({data, valid, framing_err, overrun, parity_err, busy} !== '0) begin
      failures++;
      $display("FAIL %s: data=%h valid=%b ferr=%b ovr=%b perr=%b busy=%b required all 0",
               name, data, valid, framing_err, overrun, parity_err, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_good_frame();
    int v0, f0, o0, p0;
    v0 = vcyc_n; f0 = ferr_n; o0 = ovr_n; p0 = perr_n;
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT, 1'b0, 1'b0);
    check_byte("good_a5_data");
    checks++;
    if (vcyc_n - v0 !== 1) begin
      failures++; $display("FAIL good_valid_width: cycles=%0d required 1", vcyc_n - v0);
    end
    checks++;
    if ((ferr_n - f0) + (ovr_n - o0) + (perr_n - p0) !== 0) begin
      failures++; $display("FAIL good_no_errors: error cycles=%0d required 0", (ferr_n - f0) + (ovr_n - o0) + (perr_n - p0));
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL good_busy_low: busy=%b required 0", busy);
    end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = vcyc_n; f0 = ferr_n;
    drive_bit(1'b0, 16);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL glitch_busy_during: busy=%b required 1", busy);
    end
    drive_bit(1'b1, 4 * BIT);
    checks++;
    if (vcyc_n - v0 !== 0 || ferr_n - f0 !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_reject: valid cycles=%0d ferr=%0d busy=%b required 0/0/0", vcyc_n - v0, ferr_n - f0, busy);
    end
  endtask

  task automatic test_framing();
    int v0, f0;
    v0 = vcyc_n; f0 = ferr_n;
    send_frame(8'h3C, 1'b0, 48, 1'b0, 1'b0);
    drive_bit(1'b1, 2 * BIT);
    checks++;
    if (ferr_n - f0 !== 1) begin
      failures++; $display("FAIL framing_pulse: ferr cycles=%0d required 1", ferr_n - f0);
    end
    checks++;
    if (vcyc_n - v0 !== 0 || got_q.size() !== 0) begin
      failures++; $display("FAIL framing_no_valid: valid cycles=%0d captured=%0d required 0", vcyc_n - v0, got_q.size());
    end
  endtask

  task automatic test_overrun();
    int o0;
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, BIT, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1 || data !== 8'h11) begin
      failures++; $display("FAIL hold_first: valid=%b data=%h required 1/11", valid, data);
    end
    o0 = ovr_n;
    send_frame(8'h22, 1'b1, BIT, 1'b0, 1'b0);
    checks++;
    if (ovr_n - o0 !== 1) begin
      failures++; $display("FAIL overrun_pulse: ovr cycles=%0d required 1", ovr_n - o0);
    end
    checks++;
    if (valid !== 1'b1 || data !== 8'h11 || got_q.size() !== 0) begin
      failures++; $display("FAIL overrun_keep: valid=%b data=%h captured=%0d required 1/11/0", valid, data, got_q.size());
    end
    ready = 1'b1;
    check_byte("overrun_drain");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      failures++; $display("FAIL overrun_valid_drop: valid=%b required 0", valid);
    end
  endtask

  task automatic test_reset_midframe();
    int v0, f0, o0;
    ready = 1'b1;
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, 4 * BIT + BIT / 2);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL midframe_busy: busy=%b required 1", busy);
    end
    rst = 1'b0;
    #1;
    check_outputs_zero("midframe_reset_immediate");
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    v0 = vcyc_n; f0 = ferr_n; o0 = ovr_n;
    drive_bit(1'b1, 8 * BIT);
    checks++;
    if (vcyc_n - v0 !== 0 || ferr_n - f0 !== 0 || ovr_n - o0 !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL midframe_abandon: valid=%0d ferr=%0d ovr=%0d busy=%b required 0", vcyc_n - v0, ferr_n - f0, ovr_n - o0, busy);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BIT, 1'b0, 1'b0);
    check_byte("after_reset_5a");
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    int p0;
    p0 = perr_n;
    ready = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, BIT, 1'b1, 1'b0);
    check_byte("parity_data_07");
    checks++;
    if (perr_n - p0 !== 1) begin
      failures++; $display("FAIL parity_pulse: perr cycles=%0d required 1", perr_n - p0);
    end
  endtask
`endif

  task automatic test_final();
    checks++;
`ifdef SERIAL_RX_PARITY_EN
    if (perr_n !== 1) begin
      failures++; $display("FAIL parity_total: perr cycles=%0d required 1", perr_n);
    end
`else
    if (perr_n !== 0) begin
      failures++; $display("FAIL parity_tied: perr cycles=%0d required 0", perr_n);
    end
`endif
    checks++;
    if (exp_q.size() !== 0 || got_q.size() !== 0) begin
      failures++; $display("FAIL scoreboard_empty: exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    test_final();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
